// File: rtl/fp_mul_pkg.sv
// Shared constants and state encoding for the iterative floating-point multiplier.
package fp_mul_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;
  localparam int unsigned BIAS_DEF  = (1 << (EXP_W_DEF - 1)) - 1;

  localparam logic [EXP_W_DEF-1:0] INF_EXP_DEF = '1;
  localparam logic [EXP_W_DEF-1:0] QNAN_EXP_DEF = '1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StNorm = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  function automatic int unsigned exp_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mul_shift_add.sv
// One-bit-per-cycle shift-and-add mantissa multiplier with stall and last-iteration pulse.
module fp_mul_shift_add
  import fp_mul_pkg::*;
#(
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [MAN_W:0]   mcand_i,
  input  logic [MAN_W:0]   mplier_i,
  output logic [MAN_W+1:0] prod_hi_o,
  output logic             last_o
);

  localparam int unsigned CntW = $clog2(MAN_W + 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAN_W);

  logic [MAN_W:0]   mcand_q, mcand_d;
  logic [MAN_W:0]   acc_q, acc_d;
  logic [MAN_W:0]   mplier_q, mplier_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [MAN_W+1:0] sum;

  always_comb begin
    sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = mcand_i;
      acc_d    = '0;
      mplier_d = mplier_i;
      cnt_d    = '0;
    end else if (run_i) begin
      // Carry lives in sum's MSB; the right shift drops it into the accumulator.
      acc_d    = sum[MAN_W+1:1];
      mplier_d = {sum[0], mplier_q[MAN_W:1]};
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign last_o    = run_i && !load_i && (cnt_q == LastCnt);
  assign prod_hi_o = {acc_q, mplier_q[MAN_W]};

endmodule

// File: rtl/fp_mul_datapath.sv
// Iterative FP multiplier datapath: operand latch, special-case decode, normalise, result hold.
module fp_mul_datapath
  import fp_mul_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic                   CLK,
  input  logic                   Reset_n,
  input  logic                   Init_En,
  input  logic                   RE,
  input  logic                   WE,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic [EXP_W+MAN_W:0]   Result,
  output logic                   DoneC,
  output logic                   Ovf,
  output logic                   Unf
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] ExpOnes = '1;
  localparam logic signed [EXP_W+1:0] BiasE   = (EXP_W+2)'(exp_bias(EXP_W));
  localparam logic signed [EXP_W+1:0] ExpMaxE = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNan = {1'b0, ExpOnes, 1'b1, {(MAN_W-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic             sa_q, sb_q, fa_q, fb_q;
  logic [EXP_W-1:0] ea_q, eb_q;
  logic [W-1:0]     result_q, result_d;
  logic             done_q, done_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [MAN_W:0]   mcand, mplier;
  logic [MAN_W+1:0] prod_hi;
  logic             run, last;

  assign mcand  = (A[W-2:MAN_W] != '0) ? {1'b1, A[MAN_W-1:0]} : '0;
  assign mplier = (B[W-2:MAN_W] != '0) ? {1'b1, B[MAN_W-1:0]} : '0;
  assign run    = RE && !Init_En && (state_q == StMul);

  fp_mul_shift_add #(
    .MAN_W (MAN_W)
  ) u_shift_add (
    .clk_i     (CLK),
    .rst_ni    (Reset_n),
    .load_i    (Init_En),
    .run_i     (run),
    .mcand_i   (mcand),
    .mplier_i  (mplier),
    .prod_hi_o (prod_hi),
    .last_o    (last)
  );

  logic                    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign, inc;
  logic signed [EXP_W+1:0] e;
  logic [MAN_W-1:0]        man_n;
  logic [W-1:0]            norm_res;
  logic                    norm_ovf, norm_unf;

  always_comb begin
    a_nan  = (ea_q == ExpOnes) && fa_q;
    b_nan  = (eb_q == ExpOnes) && fb_q;
    a_inf  = (ea_q == ExpOnes) && !fa_q;
    b_inf  = (eb_q == ExpOnes) && !fb_q;
    a_zero = (ea_q == '0);
    b_zero = (eb_q == '0);
    sign   = sa_q ^ sb_q;
    inc    = prod_hi[MAN_W+1];
    man_n  = inc ? prod_hi[MAN_W:1] : prod_hi[MAN_W-1:0];
    e      = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BiasE
           + $signed({{(EXP_W+1){1'b0}}, inc});
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      norm_res = QNan;
    end else if (a_inf || b_inf) begin
      norm_res = {sign, ExpOnes, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      norm_res = {sign, {(W-1){1'b0}}};
    end else if (e >= ExpMaxE) begin
      norm_res = {sign, ExpOnes, {MAN_W{1'b0}}};
      norm_ovf = 1'b1;
    end else if (e[EXP_W+1] || (e == '0)) begin
      norm_res = {sign, {(W-1){1'b0}}};
      norm_unf = 1'b1;
    end else begin
      norm_res = {sign, e[EXP_W-1:0], man_n};
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (Init_En) begin
      state_d = StMul;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case (state_q)
        StMul:  if (last) state_d = StNorm;
        StNorm: begin
          if (WE) begin
            state_d  = StDone;
            result_d = norm_res;
            ovf_d    = norm_ovf;
            unf_d    = norm_unf;
            done_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      fa_q     <= 1'b0;
      fb_q     <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      if (Init_En) begin
        sa_q <= A[W-1];
        sb_q <= B[W-1];
        ea_q <= A[W-2:MAN_W];
        eb_q <= B[W-2:MAN_W];
        fa_q <= (A[MAN_W-1:0] != '0);
        fb_q <= (B[MAN_W-1:0] != '0);
      end
    end
  end

  assign Result = result_q;
  assign DoneC  = done_q;
  assign Ovf    = ovf_q;
  assign Unf    = unf_q;

endmodule

// File: tb/tb_fp_mul_datapath.sv
// Vector, corner-sequence and randomized checks of fp_mul_datapath (binary32 defaults).
module tb_fp_mul_datapath;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Init_En = 1'b0;
  logic        RE = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Result;
  logic        DoneC, Ovf, Unf;

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  fp_mul_datapath dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .Init_En (Init_En),
    .RE      (RE),
    .WE      (WE),
    .A       (A),
    .B       (B),
    .Result  (Result),
    .DoneC   (DoneC),
    .Ovf     (Ovf),
    .Unf     (Unf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: real-number product of the significands, truncated, with IEEE field rules.
  function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e;
    longint      ma, mb, p, man;
    logic        s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    nan_a = (ea == 255) && (ma != 0);
    nan_b = (eb == 255) && (mb != 0);
    inf_a = (ea == 255) && (ma == 0);
    inf_b = (eb == 255) && (mb == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) return {2'b00, 32'h7FC00000};
    if (inf_a || inf_b) return {2'b00, s, 8'hFF, 23'h0};
    if (zero_a || zero_b) return {2'b00, s, 31'h0};
    p = (ma + 64'd8388608) * (mb + 64'd8388608);
    if (p >= (64'd1 << 47)) begin
      man = (p >> 24) & 64'h7FFFFF;
      e = ea + eb - 127 + 1;
    end else begin
      man = (p >> 23) & 64'h7FFFFF;
      e = ea + eb - 127;
    end
    if (e >= 255) return {2'b01, s, 8'hFF, 23'h0};
    if (e <= 0) return {2'b10, s, 31'h0};
    return {2'b00, s, e[7:0], man[22:0]};
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    A = a;
    B = b;
    Init_En = 1'b1;
    RE = 1'b1;
    WE = 1'b1;
    @(negedge CLK);
    Init_En = 1'b0;
  endtask

  // lat = number of clock edges after the load edge until DoneC is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!DoneC && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
    chk("done_reached", {31'h0, DoneC}, 32'h1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    start(a, b);
    wait_done(lat);
  endtask

  vec_t vecs[9];

  initial begin
    int lat, lat2;
    logic [33:0] exp_r;
    logic [31:0] ra, rb;

    vecs[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    vecs[1] = '{32'hC0400000, 32'h3F000000, 32'hBFC00000, 1'b0, 1'b0};
    vecs[2] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0};
    vecs[3] = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
    vecs[4] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0};
    vecs[5] = '{32'hFFC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
    vecs[6] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0};
    vecs[7] = '{32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1'b0};
    vecs[8] = '{32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 1'b0};

    #1 Reset_n = 1'b0;
    #10;
    chk("reset_result", Result, 32'h0);
    chk("reset_done", {31'h0, DoneC}, 32'h0);
    chk("reset_flags", {30'h0, Ovf, Unf}, 32'h0);
    @(negedge CLK);
    Reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_result", i), Result, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), {30'h0, Ovf, Unf}, {30'h0, vecs[i].ovf, vecs[i].unf});
      if (i == 0) chk("vec0_latency", 32'(lat), 32'd25);
    end

    // Result and DoneC hold after WE drops.
    run_op(32'hC0400000, 32'h3F000000, lat);
    WE = 1'b0;
    RE = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      chk("hold_result", Result, 32'hBFC00000);
      chk("hold_done", {31'h0, DoneC}, 32'h1);
    end

    // RE stall for 5 cycles mid-MUL.
    start(32'h3FC00000, 32'h40000000);
    repeat (5) @(negedge CLK);
    RE = 1'b0;
    repeat (5) @(negedge CLK);
    RE = 1'b1;
    wait_done(lat);
    chk("stall_latency", 32'(lat + 10), 32'd30);
    chk("stall_result", Result, 32'h40400000);

    // WE low for 3 cycles while in NORM.
    start(32'h3FC00000, 32'h40000000);
    WE = 1'b0;
    repeat (27) @(negedge CLK);
    chk("we_low_no_done", {31'h0, DoneC}, 32'h0);
    WE = 1'b1;
    wait_done(lat);
    chk("we_low_latency", 32'(lat + 27), 32'd28);

    // Restart mid-operation with new operands.
    start(32'h3FC00000, 32'h40000000);
    repeat (10) @(negedge CLK);
    A = 32'hC0400000;
    B = 32'h3F000000;
    Init_En = 1'b1;
    @(negedge CLK);
    Init_En = 1'b0;
    chk("restart_done_low", {31'h0, DoneC}, 32'h0);
    wait_done(lat);
    chk("restart_latency", 32'(lat), 32'd25);
    chk("restart_result", Result, 32'hBFC00000);

    // Asynchronous reset mid-MUL, then idle with no load.
    start(32'h3FC00000, 32'h40000000);
    repeat (12) @(negedge CLK);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_result", Result, 32'h0);
    chk("async_rst_done", {31'h0, DoneC}, 32'h0);
    @(negedge CLK);
    Reset_n = 1'b1;
    RE = 1'b1;
    WE = 1'b1;
    repeat (30) @(negedge CLK);
    chk("idle_done", {31'h0, DoneC}, 32'h0);
    chk("idle_result", Result, 32'h0);

    // Randomized operands, with forced zero/all-ones exponents now and then.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 7) == 0) rb[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 1) != 0) rb[30:23] = 8'(254 - int'(ra[30:23]) + $urandom_range(0, 20));
      exp_r = ref_mul(ra, rb);
      run_op(ra, rb, lat2);
      chk($sformatf("rand%0d_%h_%h_result", i, ra, rb), Result, exp_r[31:0]);
      chk($sformatf("rand%0d_flags", i), {30'h0, Ovf, Unf}, {30'h0, exp_r[32], exp_r[33]});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
